// File: rtl/maze_pkg.sv
// Shared definitions for the maze game blocks (carver, player, renderer).
// Contents:
//   GRID_DEFAULT - default maze side length in cells
//   state_t      - player game state encoding (IDLE, PLAY, WON)
//   dir_t        - move direction codes (UP=00, LEFT=01, DOWN=10, RIGHT=11)
package maze_pkg;

    localparam int GRID_DEFAULT = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PLAY = 2'b01,
        ST_WON  = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_LEFT  = 2'b01,
        DIR_DOWN  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_t;

endpackage

// File: rtl/maze_player_if.sv
// Maze description bus from the carver to its consumers.
// Signals:
//   maze_ready  - level, carver has finished the maze
//   maze_data   - GRID*GRID cell map, bit x+GRID*y, 1 = open, 0 = wall
//   maze_width  - active maze width in cells (1..16)
//   maze_height - active maze height in cells (1..16)
//   finish_x/y  - goal cell
// Modports: master (carver side, drives), slave (player side, samples).
interface maze_player_if
    import maze_pkg::*;
#(
    parameter int GRID = GRID_DEFAULT
);

    logic                   maze_ready;
    logic [GRID*GRID-1:0]   maze_data;
    logic [4:0]             maze_width;
    logic [4:0]             maze_height;
    logic [3:0]             finish_x;
    logic [3:0]             finish_y;

    modport master (
        output maze_ready, maze_data, maze_width, maze_height, finish_x, finish_y
    );

    modport slave (
        input  maze_ready, maze_data, maze_width, maze_height, finish_x, finish_y
    );

endinterface

// File: rtl/maze_player_btn_repeat.sv
// btn_repeat: rising-edge detector with hold-to-repeat for one button.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   btn          - synchronous, debounced, active-high button
//   repeat_time  - cycles between repeats minus one (0 = every cycle)
//   req          - one-cycle move request (combinational from btn + state)
module btn_repeat (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn,
    input  logic [25:0] repeat_time,
    output logic        req
);

    logic        armed;
    logic        prev;
    logic        active;
    logic [25:0] cnt;
    logic        rise;
    logic        hold_fire;

    // armed stays low for the first cycle after reset so a button that was
    // already held through reset is absorbed into prev instead of looking
    // like a fresh edge. Repeats only follow a hold that began with a real edge.
    always_comb begin
        rise      = armed && btn && !prev;
        hold_fire = active && btn && prev && (cnt == repeat_time);
        req       = rise || hold_fire;
    end

    // Counter restarts on every request and on release, so a repeat fires
    // repeat_time+1 cycles after the previous request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed  <= 1'b0;
            prev   <= 1'b0;
            active <= 1'b0;
            cnt    <= '0;
        end else begin
            armed <= 1'b1;
            prev  <= btn;
            if (!btn) begin
                active <= 1'b0;
                cnt    <= '0;
            end else if (rise) begin
                active <= 1'b1;
                cnt    <= '0;
            end else if (hold_fire) begin
                cnt <= '0;
            end else if (active) begin
                cnt <= cnt + 26'd1;
            end
        end
    end

endmodule

// File: rtl/maze_player.sv
// maze_player: moves the player through a snapshot of the carved maze.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   new_game            - one-cycle pulse, aborts current game (back to IDLE)
//   maze                - maze description bus (slave side)
//   btn_up/down/left/right - debounced buttons, edge + hold-repeat
//   repeat_time         - hold-repeat interval in cycles
//   player_x/player_y   - current player cell (registered)
//   playing, won        - registered state flags
//   move_count          - accepted moves this game, saturating
module maze_player
    import maze_pkg::*;
#(
    parameter int GRID  = GRID_DEFAULT,
    parameter int CNT_W = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             new_game,
    maze_player_if.slave     maze,
    input  logic             btn_up,
    input  logic             btn_down,
    input  logic             btn_left,
    input  logic             btn_right,
    input  logic [25:0]      repeat_time,
    output logic [3:0]       player_x,
    output logic [3:0]       player_y,
    output logic             playing,
    output logic             won,
    output logic [CNT_W-1:0] move_count
);

    localparam int CELLS = GRID * GRID;
    localparam int IDX_W = (CELLS > 1) ? $clog2(CELLS) : 1;

    state_t           state;
    state_t           state_next;
    logic [CELLS-1:0] snap_data;
    logic [4:0]       snap_w;
    logic [4:0]       snap_h;
    logic [3:0]       snap_fx;
    logic [3:0]       snap_fy;
    logic             req_up;
    logic             req_down;
    logic             req_left;
    logic             req_right;
    logic             have_req;
    dir_t             dir;
    logic [4:0]       tx;
    logic [4:0]       ty;
    logic             in_bounds;
    logic [IDX_W-1:0] cell_idx;
    logic             at_finish;
    logic             move_ok;

    btn_repeat u_rep_up    (.clk(clk), .rst_n(rst_n), .btn(btn_up),    .repeat_time(repeat_time), .req(req_up));
    btn_repeat u_rep_down  (.clk(clk), .rst_n(rst_n), .btn(btn_down),  .repeat_time(repeat_time), .req(req_down));
    btn_repeat u_rep_left  (.clk(clk), .rst_n(rst_n), .btn(btn_left),  .repeat_time(repeat_time), .req(req_left));
    btn_repeat u_rep_right (.clk(clk), .rst_n(rst_n), .btn(btn_right), .repeat_time(repeat_time), .req(req_right));

    // Pick one request (up > left > down > right) and evaluate its target.
    // Targets use 5 bits so stepping off the 0 edge becomes 31 and stepping
    // off 15 becomes 16; both fail the bounds test instead of wrapping.
    // No moves once the player sits on the goal: the WON transition follows.
    always_comb begin
        have_req = 1'b1;
        dir      = DIR_UP;
        if (req_up)         dir = DIR_UP;
        else if (req_left)  dir = DIR_LEFT;
        else if (req_down)  dir = DIR_DOWN;
        else if (req_right) dir = DIR_RIGHT;
        else                have_req = 1'b0;

        tx = {1'b0, player_x};
        ty = {1'b0, player_y};
        unique case (dir)
            DIR_UP:    ty = ty - 5'd1;
            DIR_DOWN:  ty = ty + 5'd1;
            DIR_LEFT:  tx = tx - 5'd1;
            DIR_RIGHT: tx = tx + 5'd1;
        endcase

        in_bounds = (tx < snap_w) && (ty < snap_h)
                    && (int'(tx) < GRID) && (int'(ty) < GRID);
        cell_idx  = IDX_W'(int'(ty) * GRID + int'(tx));
        at_finish = (player_x == snap_fx) && (player_y == snap_fy);
        move_ok   = have_req && (state == ST_PLAY) && !at_finish
                    && in_bounds && snap_data[cell_idx];
    end

    // Next-state logic; new_game overrides everything else.
    // Starting on the goal cell skips PLAY entirely.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: begin
                if (maze.maze_ready) begin
                    if (maze.finish_x == 4'd0 && maze.finish_y == 4'd0)
                        state_next = ST_WON;
                    else
                        state_next = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (at_finish)
                    state_next = ST_WON;
            end
            ST_WON:  state_next = ST_WON;
            default: state_next = ST_IDLE;
        endcase
        if (new_game)
            state_next = ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            playing <= 1'b0;
            won     <= 1'b0;
        end else begin
            state   <= state_next;
            playing <= (state_next == ST_PLAY);
            won     <= (state_next == ST_WON);
        end
    end

    // Snapshot is taken on game start and never touched again until the
    // next start, so later carver activity cannot disturb a running game.
    // Position is kept across WON and IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_data  <= '0;
            snap_w     <= '0;
            snap_h     <= '0;
            snap_fx    <= '0;
            snap_fy    <= '0;
            player_x   <= '0;
            player_y   <= '0;
            move_count <= '0;
        end else if (new_game) begin
            move_count <= move_count;
        end else if (state == ST_IDLE && maze.maze_ready) begin
            snap_data  <= maze.maze_data;
            snap_w     <= maze.maze_width;
            snap_h     <= maze.maze_height;
            snap_fx    <= maze.finish_x;
            snap_fy    <= maze.finish_y;
            player_x   <= '0;
            player_y   <= '0;
            move_count <= '0;
        end else if (move_ok) begin
            player_x <= tx[3:0];
            player_y <= ty[3:0];
            if (move_count != '1)
                move_count <= move_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_maze_player.sv
// Self-checking bench for maze_player: table-driven vectors, scoreboard queue
// of expectations, plus hand sequences for hold-repeat, win, reset and
// counter saturation.
module tb_maze_player;
    import maze_pkg::*;

    localparam int GRID  = 16;
    localparam int CNT_W = 10;

    typedef struct {
        logic [3:0]       btn;
        logic             ng;
        logic [3:0]       x;
        logic [3:0]       y;
        logic [CNT_W-1:0] cnt;
        logic             playing;
        logic             won;
    } vec_t;

    typedef struct {
        string            tag;
        logic [3:0]       x;
        logic [3:0]       y;
        logic [CNT_W-1:0] cnt;
        logic             playing;
        logic             won;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             new_game;
    logic             btn_up;
    logic             btn_down;
    logic             btn_left;
    logic             btn_right;
    logic [25:0]      repeat_time;
    logic [3:0]       player_x;
    logic [3:0]       player_y;
    logic             playing;
    logic             won;
    logic [CNT_W-1:0] move_count;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    vec_t tbl_a[14];
    vec_t tbl_b[9];

    maze_player_if #(.GRID(GRID)) mif();

    maze_player #(.GRID(GRID), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .new_game   (new_game),
        .maze       (mif),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .repeat_time(repeat_time),
        .player_x   (player_x),
        .player_y   (player_y),
        .playing    (playing),
        .won        (won),
        .move_count (move_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time expired, required finish before 200000");
        $fatal(1, "[TB] timeout");
    end

    function automatic vec_t mk(input logic [3:0] btn, input logic ng, input int x, input int y,
                                input int cnt, input logic pl, input logic w);
        vec_t v;
        v.btn     = btn;
        v.ng      = ng;
        v.x       = 4'(x);
        v.y       = 4'(y);
        v.cnt     = CNT_W'(cnt);
        v.playing = pl;
        v.won     = w;
        return v;
    endfunction

    function automatic logic [GRID*GRID-1:0] row0_open(input int n);
        logic [GRID*GRID-1:0] m;
        m = '0;
        for (int i = 0; i < n; i++) m[i] = 1'b1;
        return m;
    endfunction

    task automatic push_exp(input string tag, input int x, input int y, input int cnt,
                            input logic pl, input logic w);
        exp_t e;
        e.tag     = tag;
        e.x       = 4'(x);
        e.y       = 4'(y);
        e.cnt     = CNT_W'(cnt);
        e.playing = pl;
        e.won     = w;
        exp_q.push_back(e);
    endtask

    task automatic check_output();
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL scoreboard: got empty queue, required an expectation");
            return;
        end
        e = exp_q.pop_front();
        if ({player_x, player_y, move_count, playing, won} !==
            {e.x, e.y, e.cnt, e.playing, e.won}) begin
            errors++;
            $display("[TB] FAIL %s: got x=%0d y=%0d cnt=%0d playing=%0b won=%0b, required x=%0d y=%0d cnt=%0d playing=%0b won=%0b",
                     e.tag, player_x, player_y, move_count, playing, won,
                     e.x, e.y, e.cnt, e.playing, e.won);
        end
    endtask

    task automatic check_now(input string tag, input int x, input int y, input int cnt,
                             input logic pl, input logic w);
        push_exp(tag, x, y, cnt, pl, w);
        check_output();
    endtask

    // Drive one cycle of buttons/new_game at the falling edge, expect the
    // registered result just after the following rising edge.
    task automatic apply_stimulus(input vec_t v, input string tag);
        @(negedge clk);
        {btn_up, btn_left, btn_down, btn_right} = v.btn;
        new_game = v.ng;
        push_exp(tag, v.x, v.y, v.cnt, v.playing, v.won);
        @(posedge clk);
        #1;
        check_output();
    endtask

    // Abort any game, then start a new one on the given maze; returns at the
    // falling edge after the start edge.
    task automatic load_maze(input logic [GRID*GRID-1:0] data, input int w, input int h,
                             input int fx, input int fy);
        @(negedge clk);
        mif.maze_data   = data;
        mif.maze_width  = 5'(w);
        mif.maze_height = 5'(h);
        mif.finish_x    = 4'(fx);
        mif.finish_y    = 4'(fy);
        {btn_up, btn_left, btn_down, btn_right} = 4'b0000;
        new_game        = 1'b1;
        mif.maze_ready  = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        @(negedge clk);
        mif.maze_ready = 1'b0;
    endtask

    // Hold right from (0,0) for ncycles; bench model of edge + repeat timing.
    task automatic hold_right(input int rt, input int ncycles, input int max_x, input string tag);
        int  x;
        bit  fire;
        x = 0;
        repeat_time = 26'(rt);
        for (int c = 1; c <= ncycles; c++) begin
            fire = (c == 1) || (((c - 1) % (rt + 1)) == 0);
            if (fire && x < max_x) x++;
            apply_stimulus(mk(4'b0001, 1'b0, x, 0, x, 1'b1, 1'b0), $sformatf("%s c%0d", tag, c));
        end
    endtask

    initial begin
        int exp_cnt;

        // btn vector order: {up, left, down, right}
        tbl_a[0]  = mk(4'b1000, 0, 0, 0, 0, 1, 0);
        tbl_a[1]  = mk(4'b0000, 0, 0, 0, 0, 1, 0);
        tbl_a[2]  = mk(4'b0100, 0, 0, 0, 0, 1, 0);
        tbl_a[3]  = mk(4'b0000, 0, 0, 0, 0, 1, 0);
        tbl_a[4]  = mk(4'b1001, 0, 0, 0, 0, 1, 0);
        tbl_a[5]  = mk(4'b0000, 0, 0, 0, 0, 1, 0);
        tbl_a[6]  = mk(4'b0001, 0, 1, 0, 1, 1, 0);
        tbl_a[7]  = mk(4'b0000, 0, 1, 0, 1, 1, 0);
        tbl_a[8]  = mk(4'b0001, 0, 1, 0, 1, 1, 0);
        tbl_a[9]  = mk(4'b0000, 0, 1, 0, 1, 1, 0);
        tbl_a[10] = mk(4'b0100, 0, 0, 0, 2, 1, 0);
        tbl_a[11] = mk(4'b0000, 0, 0, 0, 2, 1, 0);
        tbl_a[12] = mk(4'b0010, 0, 0, 0, 2, 1, 0);
        tbl_a[13] = mk(4'b0000, 0, 0, 0, 2, 1, 0);

        tbl_b[0]  = mk(4'b0001, 0, 1, 0, 1, 1, 0);
        tbl_b[1]  = mk(4'b0000, 0, 1, 0, 1, 1, 0);
        tbl_b[2]  = mk(4'b0001, 0, 2, 0, 2, 1, 0);
        tbl_b[3]  = mk(4'b0000, 0, 2, 0, 2, 0, 1);
        tbl_b[4]  = mk(4'b0100, 0, 2, 0, 2, 0, 1);
        tbl_b[5]  = mk(4'b0000, 0, 2, 0, 2, 0, 1);
        tbl_b[6]  = mk(4'b0000, 1, 2, 0, 2, 0, 0);
        tbl_b[7]  = mk(4'b0001, 0, 2, 0, 2, 0, 0);
        tbl_b[8]  = mk(4'b0000, 0, 2, 0, 2, 0, 0);

        rst_n          = 1'b0;
        new_game       = 1'b0;
        {btn_up, btn_left, btn_down, btn_right} = 4'b0000;
        repeat_time    = 26'd100;
        mif.maze_ready = 1'b0;
        mif.maze_data  = '0;
        mif.maze_width = 5'd16;
        mif.maze_height = 5'd16;
        mif.finish_x   = 4'd15;
        mif.finish_y   = 4'd15;
        #1;
        check_now("reset state", 0, 0, 0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Two open cells; snapshot must ignore later maze_data changes.
        load_maze(row0_open(2), 16, 16, 15, 15);
        check_now("game start", 0, 0, 0, 1'b1, 1'b0);
        mif.maze_data = '1;
        for (int i = 0; i < 14; i++)
            apply_stimulus(tbl_a[i], $sformatf("table_a[%0d]", i));

        // Hold-repeat along a corridor of six open cells.
        load_maze(row0_open(6), 16, 16, 15, 15);
        hold_right(3, 20, 5, "repeat rt3");
        apply_stimulus(mk(4'b0000, 0, 5, 0, 5, 1, 0), "repeat rt3 release");
        load_maze(row0_open(6), 16, 16, 15, 15);
        hold_right(0, 7, 5, "repeat rt0");
        apply_stimulus(mk(4'b0000, 0, 5, 0, 5, 1, 0), "repeat rt0 release");

        // Win at (2,0), presses ignored in WON, new_game back to IDLE.
        repeat_time = 26'd100;
        load_maze(row0_open(3), 16, 16, 2, 0);
        for (int i = 0; i < 9; i++)
            apply_stimulus(tbl_b[i], $sformatf("table_b[%0d]", i));

        // Finish on the start cell goes straight to WON.
        load_maze(row0_open(3), 16, 16, 0, 0);
        check_now("finish at origin", 0, 0, 0, 1'b0, 1'b1);

        // Narrow maze: width 1 rejects the step right even though the cell is open.
        load_maze(row0_open(3), 1, 16, 15, 15);
        apply_stimulus(mk(4'b0001, 0, 0, 0, 0, 1, 0), "width bound");
        apply_stimulus(mk(4'b0000, 0, 0, 0, 0, 1, 0), "width bound release");

        // Asynchronous reset mid-game with right held through release.
        repeat_time = 26'd3;
        load_maze(row0_open(6), 16, 16, 15, 15);
        apply_stimulus(mk(4'b0001, 0, 1, 0, 1, 1, 0), "pre-reset move");
        #2;
        rst_n          = 1'b0;
        mif.maze_ready = 1'b1;
        #1;
        check_now("async reset", 0, 0, 0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        apply_stimulus(mk(4'b0001, 0, 0, 0, 0, 1, 0), "post-reset start");
        mif.maze_ready = 1'b0;
        for (int i = 0; i < 8; i++)
            apply_stimulus(mk(4'b0001, 0, 0, 0, 0, 1, 0), $sformatf("held through reset %0d", i));
        apply_stimulus(mk(4'b0000, 0, 0, 0, 0, 1, 0), "post-reset release");
        apply_stimulus(mk(4'b0001, 0, 1, 0, 1, 1, 0), "post-reset fresh press");

        // Saturation: alternate right/left so every cycle is a fresh edge.
        repeat_time = 26'd100;
        load_maze(row0_open(2), 16, 16, 15, 15);
        for (int n = 1; n <= 1030; n++) begin
            exp_cnt = (n < 1023) ? n : 1023;
            if (n % 2 == 1)
                apply_stimulus(mk(4'b0001, 0, 1, 0, exp_cnt, 1, 0), $sformatf("saturate %0d", n));
            else
                apply_stimulus(mk(4'b0100, 0, 0, 0, exp_cnt, 1, 0), $sformatf("saturate %0d", n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/maze_player.md
MAZE_PLAYER -- requirements
Module: maze_player

Interface
REQ-001 SHALL have parameter GRID, default 16, maze side length in cells; the bit index of cell (x,y) is x + GRID*y.
REQ-002 SHALL have parameter CNT_W, default 10, move-counter width.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port new_game  input  1  one-cycle pulse that aborts the current game.
REQ-006 SHALL have port maze_ready  input  1  level; carver finished.
REQ-007 SHALL have port maze_data  input  GRID*GRID  cell map; 1 = carved (open), 0 = wall.
REQ-008 SHALL have port maze_width, maze_height  input  5 each  active maze size, 1..16.
REQ-009 SHALL have port finish_x, finish_y  input  4 each  goal cell.
REQ-010 SHALL have ports btn_up, btn_down, btn_left, btn_right  input  1 each  synchronous, debounced, active-high.
REQ-011 SHALL have port repeat_time  input  26  hold-repeat interval in cycles.
REQ-012 SHALL have ports player_x, player_y  output  4 each  current player cell.
REQ-013 SHALL have port playing  output  1  high in PLAY.
REQ-014 SHALL have port won  output  1  high in WON.
REQ-015 SHALL have port move_count  output  CNT_W  accepted moves this game.

Function
REQ-016 SHALL implement states IDLE, PLAY, WON.
REQ-017 SHALL go IDLE->PLAY on the first clk with maze_ready=1 and new_game=0; on that edge, snapshot maze_data, maze_width, maze_height, finish_x, finish_y into internal registers, set player to (0,0), and clear move_count.
REQ-018 SHALL, in PLAY and WON, use only the snapshot; input changes SHALL have no effect until the next IDLE->PLAY transition.
REQ-019 SHALL, on new_game=1 in any state, enter IDLE next cycle; new_game SHALL override every simultaneous event.
REQ-020 SHALL select at most one request per cycle, with priority up > left > down > right.
REQ-021 SHALL issue a move request on the rising edge of a button (button now 1, previous cycle 0).
REQ-022 SHALL, while the same button stays held, issue a repeat request every repeat_time+1 cycles after the last request; the repeat counter SHALL restart on any new edge or on release.
REQ-023 SHALL treat repeat_time=0 as a request every cycle while held.
REQ-024 SHALL compute the target cell as up = y-1, down = y+1, left = x-1, right = x+1, using 5-bit arithmetic with no wrap.
REQ-025 SHALL accept a move only when the target is in bounds (0 <= tx < width, 0 <= ty < height) and the snapshot bit at the target is 1.
REQ-026 SHALL, on an accepted move, update the player position on the next edge (1-cycle latency) and increment move_count.
REQ-027 SHALL hold move_count saturated at 2^CNT_W-1.
REQ-028 SHALL ignore a rejected move: position and count unchanged, no error flag.
REQ-029 SHALL go PLAY->WON on the cycle after the player position equals the snapshot finish cell.
REQ-030 SHALL go directly to WON if (0,0) equals the finish cell at PLAY entry.
REQ-031 SHALL ignore buttons in IDLE and WON.
REQ-032 SHALL keep player_x/player_y at their last values in WON and in IDLE.

Reset
REQ-033 SHALL, while rst_n=0, force state IDLE, player_x=0, player_y=0, playing=0, won=0, move_count=0, snapshot=0, repeat counter=0, and previous-button registers=0, independent of clk.
REQ-034 SHALL, when reset is released mid-press, not issue a request for a button already high; a fresh edge is required.

Structure
REQ-035 SHALL place the state encoding, the GRID default, and the direction codes (UP=00, LEFT=01, DOWN=10, RIGHT=11) in a shared package maze_pkg, also used by the carver and the renderer.
REQ-036 SHALL implement edge detection and hold-repeat in one sub-module, btn_repeat, instantiated four times.
REQ-037 SHALL register all outputs, with no combinational path from any input to any output.

Verification
REQ-038 SHALL verify: snapshot with cells (0,0),(1,0) open, width=height=16, right pulse -> player (1,0), move_count=1 after 1 cycle.
REQ-039 SHALL verify: player (0,0), up pulse -> rejected, position (0,0), move_count=0; left pulse -> likewise.
REQ-040 SHALL verify: corridor (0..5,0) open, repeat_time=3, right held 20 cycles -> moves on cycles 1,5,9,13,17, stopping at (5,0) with move_count=5.
REQ-041 SHALL verify: up+right asserted together with only (1,0) open -> up wins and is rejected; no move occurs.
REQ-042 SHALL verify: finish=(2,0), moves to (2,0) -> won=1 next cycle; further presses leave move_count=2; new_game -> IDLE with won=0.
REQ-043 SHALL verify: rst_n=0 asserted mid-PLAY between clk edges -> all outputs 0 immediately; btn_right held across release -> no move.
